// File: rtl/axi4_dec_pkg.sv
// Shared encodings for the AXI4 region decoder: result codes, config field
// selectors and region control bit positions.
package axi4_dec_pkg;

  // Decode result codes
  localparam logic [1:0] DEC_OK        = 2'd0;
  localparam logic [1:0] DEC_NOMATCH   = 2'd1;
  localparam logic [1:0] DEC_MST_DENY  = 2'd2;
  localparam logic [1:0] DEC_PROT_DENY = 2'd3;

  // cfg_field selectors
  localparam logic [1:0] CFG_BASE  = 2'd0;
  localparam logic [1:0] CFG_LIMIT = 2'd1;
  localparam logic [1:0] CFG_PERM  = 2'd2;
  localparam logic [1:0] CFG_CTRL  = 2'd3;

  // Bit positions inside a region's ctrl word
  localparam int CTRL_EN   = 0;
  localparam int CTRL_PRIV = 1;
  localparam int CTRL_SEC  = 2;

endpackage

// File: rtl/axi4_region_match.sv
// Single-region address compare: hit when enabled and base <= addr <= limit
// (unsigned, inclusive). A region with base > limit can never hit.
module axi4_region_match #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] limit,
  input  logic                  en,
  output logic                  hit
);

  assign hit = en && (addr >= base) && (addr <= limit);

endmodule

// File: rtl/axi4_region_decoder_pipe.sv
// Registered AXI4 region decoder. Runtime-programmable region table
// (base/limit/perm/ctrl), one AW/AR decode per cycle through a single
// valid/ready register stage, fixed lowest-index priority on overlap.
// Optional error capture registers: define AXI4_DEC_ERR_CAPTURE_EN.
module axi4_region_decoder_pipe
  import axi4_dec_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int NUM_MASTERS = 4,
  parameter int ERR_CNT_W   = 16,
  localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_prot,
  input  logic [MID_W-1:0]      req_mid,
  input  logic                  req_is_write,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [NUM_SLAVES-1:0] dec_slave_sel,
  output logic                  dec_error,
  output logic [1:0]            dec_err_code,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  output logic [MID_W-1:0]      dec_mid,
  output logic                  dec_is_write,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [1:0]            cfg_field,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata,
  input  logic                  cfg_lock,
  output logic                  cfg_locked,
  output logic [ERR_CNT_W-1:0]  err_count
`ifdef AXI4_DEC_ERR_CAPTURE_EN
  ,
  output logic                  err_cap_valid,
  output logic [ADDR_WIDTH-1:0] err_cap_addr,
  output logic [MID_W-1:0]      err_cap_mid,
  output logic [1:0]            err_cap_code,
  input  logic                  err_cap_clr
`endif
);

  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  base_q, limit_q;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] perm_q;
  logic [NUM_SLAVES-1:0][2:0]             ctrl_q;

  logic [NUM_SLAVES-1:0]  hit;
  logic                   any_hit, mid_ok, prot_bad, accept;
  logic [NUM_SLAVES-1:0]  win_oh, sel_d;
  logic [NUM_MASTERS-1:0] win_perm;
  logic [2:0]             win_ctrl;
  logic [1:0]             code_d;
  logic                   unused_prot;

  // AxPROT[2] (instruction/data) plays no part in the checks
  assign unused_prot = req_prot[2];

  assign req_ready = !dec_valid || dec_ready;
  assign accept    = req_valid && req_ready;

  // Per-region compare against the current (pre-write) table
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    axi4_region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .addr  (req_addr),
      .base  (base_q[g]),
      .limit (limit_q[g]),
      .en    (ctrl_q[g][CTRL_EN]),
      .hit   (hit[g])
    );
  end

  // Lowest-index winner, then permission/prot checks on that region only
  always_comb begin
    any_hit  = 1'b0;
    win_oh   = '0;
    win_perm = '0;
    win_ctrl = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit   = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_perm  = perm_q[i];
        win_ctrl  = ctrl_q[i];
      end
    end
    // mid values with no matching perm bit stay denied
    mid_ok = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++)
      if (req_mid == MID_W'(m)) mid_ok = win_perm[m];
    prot_bad = (win_ctrl[CTRL_PRIV] && !req_prot[0]) ||
               (win_ctrl[CTRL_SEC]  &&  req_prot[1]);
    sel_d  = '0;
    if (!any_hit)     code_d = DEC_NOMATCH;
    else if (!mid_ok) code_d = DEC_MST_DENY;
    else if (prot_bad) code_d = DEC_PROT_DENY;
    else begin
      code_d = DEC_OK;
      sel_d  = win_oh;
    end
  end

  // Region table writes and sticky lock
  always_ff @(posedge aclk) begin
    if (areset) begin
      base_q     <= '0;
      limit_q    <= '0;
      perm_q     <= '1;
      ctrl_q     <= '0;
      cfg_locked <= 1'b0;
    end else begin
      if (cfg_lock) cfg_locked <= 1'b1;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (cfg_wr_en && !cfg_locked && cfg_idx == IDX_W'(i)) begin
          case (cfg_field)
            CFG_BASE:  base_q[i]  <= cfg_wdata;
            CFG_LIMIT: limit_q[i] <= cfg_wdata;
            CFG_PERM:  perm_q[i]  <= cfg_wdata[NUM_MASTERS-1:0];
            default:   ctrl_q[i]  <= cfg_wdata[2:0];
          endcase
        end
      end
    end
  end

  // Result register stage; fields hold while stalled
  always_ff @(posedge aclk) begin
    if (areset) begin
      dec_valid     <= 1'b0;
      dec_slave_sel <= '0;
      dec_error     <= 1'b0;
      dec_err_code  <= DEC_OK;
      dec_addr      <= '0;
      dec_mid       <= '0;
      dec_is_write  <= 1'b0;
    end else if (accept) begin
      dec_valid     <= 1'b1;
      dec_slave_sel <= sel_d;
      dec_error     <= (code_d != DEC_OK);
      dec_err_code  <= code_d;
      dec_addr      <= req_addr;
      dec_mid       <= req_mid;
      dec_is_write  <= req_is_write;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  // Saturating count of error results, bumped when the result loads
  always_ff @(posedge aclk) begin
    if (areset)
      err_count <= '0;
    else if (accept && code_d != DEC_OK && err_count != '1)
      err_count <= err_count + 1'b1;
  end

`ifdef AXI4_DEC_ERR_CAPTURE_EN
  // First-error capture; a new error in the clear cycle wins over the clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_cap_valid <= 1'b0;
      err_cap_addr  <= '0;
      err_cap_mid   <= '0;
      err_cap_code  <= DEC_OK;
    end else if (accept && code_d != DEC_OK && (!err_cap_valid || err_cap_clr)) begin
      err_cap_valid <= 1'b1;
      err_cap_addr  <= req_addr;
      err_cap_mid   <= req_mid;
      err_cap_code  <= code_d;
    end else if (err_cap_clr) begin
      err_cap_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_region_decoder_pipe.sv
// Directed self-checking bench for axi4_region_decoder_pipe (default build).
module tb_axi4_region_decoder_pipe;
  import axi4_dec_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_prot;
  logic [1:0]  req_mid;
  logic        req_is_write;
  logic        dec_valid, dec_ready;
  logic [3:0]  dec_slave_sel;
  logic        dec_error;
  logic [1:0]  dec_err_code;
  logic [31:0] dec_addr;
  logic [1:0]  dec_mid;
  logic        dec_is_write;
  logic        cfg_wr_en;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic        cfg_lock, cfg_locked;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi4_region_decoder_pipe dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_prot(req_prot), .req_mid(req_mid), .req_is_write(req_is_write),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_slave_sel(dec_slave_sel),
    .dec_error(dec_error), .dec_err_code(dec_err_code), .dec_addr(dec_addr),
    .dec_mid(dec_mid), .dec_is_write(dec_is_write),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata), .cfg_lock(cfg_lock), .cfg_locked(cfg_locked),
    .err_count(err_count)
  );

  // Drivers: all changes happen 1ns after a rising edge
  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [1:0] fld, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_wdata = d;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] mid, input logic [2:0] prot,
                      input logic wr);
    req_valid = 1'b1; req_addr = a; req_mid = mid; req_prot = prot; req_is_write = wr;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step(); step();
    areset = 1'b0;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dec_valid); end
    n_checks++; if (dec_slave_sel !== 4'b0) begin n_fail++; $display("FAIL reset_sel got %b want 0000", dec_slave_sel); end
    n_checks++; if (dec_error !== 1'b0 || dec_err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err got %b/%0d want 0/0", dec_error, dec_err_code); end
    n_checks++; if (dec_addr !== 32'h0 || dec_mid !== 2'd0 || dec_is_write !== 1'b0) begin n_fail++; $display("FAIL reset_fwd got %h/%0d/%b want 0/0/0", dec_addr, dec_mid, dec_is_write); end
    n_checks++; if (cfg_locked !== 1'b0 || err_count !== 16'd0) begin n_fail++; $display("FAIL reset_cfg got lock=%b cnt=%0d want 0/0", cfg_locked, err_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_overlap();
    cfg_wr(2'd0, CFG_BASE,  32'h0000_0000);
    cfg_wr(2'd0, CFG_LIMIT, 32'h3FFF_FFFF);
    cfg_wr(2'd0, CFG_CTRL,  32'h1);
    cfg_wr(2'd1, CFG_BASE,  32'h1000_0000);
    cfg_wr(2'd1, CFG_LIMIT, 32'h13FF_FFFF);
    cfg_wr(2'd1, CFG_CTRL,  32'h1);
    send(32'h1000_0004, 2'd0, 3'b000, 1'b1);
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL ovl_valid got %b want 1", dec_valid); end
    n_checks++; if (dec_slave_sel !== 4'b0001 || dec_err_code !== DEC_OK || dec_error !== 1'b0) begin n_fail++; $display("FAIL ovl_sel got %b/%0d want 0001/0", dec_slave_sel, dec_err_code); end
    n_checks++; if (dec_addr !== 32'h1000_0004 || dec_is_write !== 1'b1) begin n_fail++; $display("FAIL ovl_fwd got %h/%b want 10000004/1", dec_addr, dec_is_write); end
    step();
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL ovl_drain got %b want 0", dec_valid); end
  endtask

  task automatic test_nomatch();
    cfg_wr(2'd0, CFG_CTRL, 32'h0);
    send(32'h1000_0004, 2'd3, 3'b000, 1'b0);
    n_checks++; if (dec_slave_sel !== 4'b0010 || dec_err_code !== DEC_OK) begin n_fail++; $display("FAIL r1_sel got %b/%0d want 0010/0", dec_slave_sel, dec_err_code); end
    n_checks++; if (dec_mid !== 2'd3 || dec_is_write !== 1'b0) begin n_fail++; $display("FAIL r1_fwd got %0d/%b want 3/0", dec_mid, dec_is_write); end
    send(32'h5000_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_slave_sel !== 4'b0 || dec_err_code !== DEC_NOMATCH || dec_error !== 1'b1) begin n_fail++; $display("FAIL nomatch got %b/%0d/%b want 0000/1/1", dec_slave_sel, dec_err_code, dec_error); end
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL cnt1 got %0d want 1", err_count); end
    // inverted region never hits
    cfg_wr(2'd2, CFG_BASE,  32'h2000_0000);
    cfg_wr(2'd2, CFG_LIMIT, 32'h1000_0000);
    cfg_wr(2'd2, CFG_CTRL,  32'h1);
    send(32'h1800_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_NOMATCH || err_count !== 16'd2) begin n_fail++; $display("FAIL inverted got %0d cnt=%0d want 1 cnt=2", dec_err_code, err_count); end
    // inclusive limit, then one past it
    send(32'h13FF_FFFF, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_slave_sel !== 4'b0010 || dec_err_code !== DEC_OK) begin n_fail++; $display("FAIL limit_in got %b/%0d want 0010/0", dec_slave_sel, dec_err_code); end
    send(32'h1400_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_NOMATCH || err_count !== 16'd3) begin n_fail++; $display("FAIL limit_out got %0d cnt=%0d want 1 cnt=3", dec_err_code, err_count); end
    // base boundary inclusive
    send(32'h1000_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_slave_sel !== 4'b0010) begin n_fail++; $display("FAIL base_in got %b want 0010", dec_slave_sel); end
  endtask

  task automatic test_perm();
    cfg_wr(2'd1, CFG_PERM, 32'hD);
    send(32'h1000_0000, 2'd1, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_MST_DENY || dec_slave_sel !== 4'b0 || err_count !== 16'd4) begin n_fail++; $display("FAIL perm_deny got %0d/%b cnt=%0d want 2/0000 cnt=4", dec_err_code, dec_slave_sel, err_count); end
    send(32'h1000_0000, 2'd2, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_OK || dec_slave_sel !== 4'b0010) begin n_fail++; $display("FAIL perm_ok got %0d/%b want 0/0010", dec_err_code, dec_slave_sel); end
  endtask

  task automatic test_prot();
    cfg_wr(2'd1, CFG_CTRL, 32'h7);
    send(32'h1000_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_PROT_DENY || err_count !== 16'd5) begin n_fail++; $display("FAIL prot_priv got %0d cnt=%0d want 3 cnt=5", dec_err_code, err_count); end
    send(32'h1000_0000, 2'd0, 3'b001, 1'b0);
    n_checks++; if (dec_err_code !== DEC_OK || dec_slave_sel !== 4'b0010) begin n_fail++; $display("FAIL prot_ok got %0d/%b want 0/0010", dec_err_code, dec_slave_sel); end
    send(32'h1000_0000, 2'd0, 3'b011, 1'b0);
    n_checks++; if (dec_err_code !== DEC_PROT_DENY || err_count !== 16'd6) begin n_fail++; $display("FAIL prot_sec got %0d cnt=%0d want 3 cnt=6", dec_err_code, err_count); end
  endtask

  // Config write and request in the same cycle: request sees the old table
  task automatic test_cfg_same_cycle();
    cfg_wr_en = 1'b1; cfg_idx = 2'd1; cfg_field = CFG_CTRL; cfg_wdata = 32'h1;
    send(32'h1000_0000, 2'd0, 3'b000, 1'b0);
    cfg_wr_en = 1'b0;
    n_checks++; if (dec_err_code !== DEC_PROT_DENY || err_count !== 16'd7) begin n_fail++; $display("FAIL same_cyc got %0d cnt=%0d want 3 cnt=7", dec_err_code, err_count); end
    send(32'h1000_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_OK || dec_slave_sel !== 4'b0010) begin n_fail++; $display("FAIL after_wr got %0d/%b want 0/0010", dec_err_code, dec_slave_sel); end
  endtask

  task automatic test_back_to_back();
    int bad_ready = 0;
    int bad_hold  = 0;
    step();
    dec_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1000_0010; req_mid = 2'd0; req_prot = 3'b000; req_is_write = 1'b1;
    step();
    req_addr = 32'h1000_0020; req_is_write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready !== 1'b0) bad_ready++;
      if (dec_valid !== 1'b1 || dec_addr !== 32'h1000_0010 || dec_slave_sel !== 4'b0010 || dec_is_write !== 1'b1) bad_hold++;
      step();
    end
    n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL bp_ready got %0d bad cycles want 0", bad_ready); end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0 (addr %h)", bad_hold, dec_addr); end
    dec_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    n_checks++; if (dec_valid !== 1'b1 || dec_addr !== 32'h1000_0020 || dec_is_write !== 1'b0) begin n_fail++; $display("FAIL bp_second got %b/%h want 1/10000020", dec_valid, dec_addr); end
    step();
    n_checks++; if (dec_valid !== 1'b0 || err_count !== 16'd7) begin n_fail++; $display("FAIL bp_drain got %b cnt=%0d want 0 cnt=7", dec_valid, err_count); end
  endtask

  task automatic test_lock_and_reset();
    cfg_lock = 1'b1;
    step();
    cfg_lock = 1'b0;
    n_checks++; if (cfg_locked !== 1'b1) begin n_fail++; $display("FAIL locked got %b want 1", cfg_locked); end
    cfg_wr(2'd0, CFG_BASE, 32'h8000_0000);
    cfg_wr(2'd0, CFG_CTRL, 32'h1);
    send(32'h0000_0100, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_err_code !== DEC_NOMATCH || err_count !== 16'd8) begin n_fail++; $display("FAIL lock_ignore got %0d cnt=%0d want 1 cnt=8", dec_err_code, err_count); end
    send(32'h1000_0000, 2'd0, 3'b000, 1'b0);
    n_checks++; if (dec_slave_sel !== 4'b0010) begin n_fail++; $display("FAIL lock_keep got %b want 0010", dec_slave_sel); end
    // leave a stalled result pending, then reset
    dec_ready = 1'b0;
    send(32'h1000_0004, 2'd0, 3'b000, 1'b0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    dec_ready = 1'b1;
    n_checks++; if (dec_valid !== 1'b0 || cfg_locked !== 1'b0 || err_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid got v=%b lock=%b cnt=%0d want 0/0/0", dec_valid, cfg_locked, err_count); end
    send(32'h1000_0000, 2'd0, 3'b001, 1'b0);
    n_checks++; if (dec_err_code !== DEC_NOMATCH || dec_slave_sel !== 4'b0) begin n_fail++; $display("FAIL rst_tbl1 got %0d/%b want 1/0000", dec_err_code, dec_slave_sel); end
    send(32'h0000_0000, 2'd0, 3'b001, 1'b0);
    n_checks++; if (dec_err_code !== DEC_NOMATCH || err_count !== 16'd2) begin n_fail++; $display("FAIL rst_tbl0 got %0d cnt=%0d want 1 cnt=2", dec_err_code, err_count); end
  endtask

  initial begin
    areset = 1'b1; req_valid = 1'b0; req_addr = '0; req_prot = '0; req_mid = '0;
    req_is_write = 1'b0; dec_ready = 1'b1; cfg_wr_en = 1'b0; cfg_idx = '0;
    cfg_field = '0; cfg_wdata = '0; cfg_lock = 1'b0;
    test_reset();
    test_overlap();
    test_nomatch();
    test_perm();
    test_prot();
    test_cfg_same_cycle();
    test_back_to_back();
    test_lock_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_region_decoder_pipe.md
Name: axi4_region_decoder_pipe

Overview:
Parametrised, registered successor of the fixed-map AXI4 address decoder. It holds a runtime-programmable region table with base, limit, per-master permission bitmap and AxPROT attributes. It decodes one AW or AR request per cycle through a valid/ready pipeline stage and reports one-hot slave select or a classified decode error. It sits between the master arbiter and the interconnect's slave-side mux/error slave.

Parameters:
ADDR_WIDTH, 32, address width; must be >= NUM_MASTERS and >= 3
NUM_SLAVES, 4, number of regions (one region per slave)
NUM_MASTERS, 4, number of master IDs; MID_W = max(1,$clog2(NUM_MASTERS))
ERR_CNT_W, 16, width of saturating error counter

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_WIDTH  AxADDR
req_prot  in  3  AxPROT
req_mid  in  MID_W  master ID
req_is_write  in  1  1=AW, 0=AR
dec_valid  out  1  decode result valid
dec_ready  in  1  downstream accepts result
dec_slave_sel  out  NUM_SLAVES  one-hot select; all zero on error
dec_error  out  1  decode error
dec_err_code  out  2  0 ok, 1 no match, 2 master denied, 3 prot denied
dec_addr  out  ADDR_WIDTH  forwarded address
dec_mid  out  MID_W  forwarded master ID
dec_is_write  out  1  forwarded direction
cfg_wr_en  in  1  config write strobe
cfg_idx  in  $clog2(NUM_SLAVES) (min 1)  region index
cfg_field  in  2  0 base, 1 limit, 2 perm, 3 ctrl
cfg_wdata  in  ADDR_WIDTH  write data (perm: [NUM_MASTERS-1:0]; ctrl: [0] enable, [1] priv_only, [2] secure_only)
cfg_lock  in  1  pulse: lock table until reset
cfg_locked  out  1  lock status
err_count  out  ERR_CNT_W  saturating count of error results

Behaviour:
- Reset: dec_valid=0, slave_sel=0, dec_error=0, err_code=0, dec_addr/mid/is_write=0, cfg_locked=0, err_count=0. All regions: base=0, limit=0, perm=all-ones, ctrl=0 (disabled).
- Pipeline: single register stage, latency 1. req_ready = !dec_valid | dec_ready, combinational, no dependency on req_valid. dec_* fields hold stable while dec_valid & !dec_ready.
- Match: region i hits when enable & base_i <= addr <= limit_i (unsigned, inclusive). A region with base > limit never hits. Overlapping hits go to the lowest index. This fixed priority is mandatory.
- Check order, applied to the winning region only:
  - No hit -> code 1.
  - perm[mid]==0 -> code 2.
  - priv_only & prot[0]==0, or secure_only & prot[1]==1 -> code 3.
  - Otherwise code 0 with sel[i]=1.
  - No fall-through to lower-priority regions on denial.
- A mid >= NUM_MASTERS is treated as denied (code 2).
- Config write: takes effect on the next clock edge. A request accepted in the same cycle decodes against the pre-write table.
- While cfg_locked=1, cfg_wr_en is ignored. cfg_lock sets cfg_locked the cycle after assertion; it stays sticky until areset.
- err_count increments on each accepted request whose result is an error, counted at the edge that loads the result. It saturates at all-ones.
- Reset mid-operation: a pending result is dropped and the table returns to defaults.

Optional Feature:
Macro AXI4_DEC_ERR_CAPTURE_EN.
- Defined: adds ports err_cap_valid (out,1), err_cap_addr (out,ADDR_WIDTH), err_cap_mid (out,MID_W), err_cap_code (out,2), err_cap_clr (in,1).
  - The first error result after reset or clear loads the capture fields and sets err_cap_valid. Later errors do not overwrite while valid.
  - err_cap_clr clears valid next cycle. If clear and a new error occur in the same cycle, the new error is captured.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package axi4_dec_pkg: err-code localparams (DEC_OK, DEC_NOMATCH, DEC_MST_DENY, DEC_PROT_DENY), cfg_field encodings, ctrl bit positions.
- Sub-module axi4_region_match: combinational per-region compare (addr vs base/limit/enable), instantiated NUM_SLAVES times via generate. Priority select and checks stay in the top level.

Test Plan:
- Program r0 = 0x0000_0000..0x3FFF_FFFF enabled, r1 = 0x1000_0000..0x13FF_FFFF enabled; request 0x1000_0004, mid 0 -> sel=4'b0001, code 0 one cycle later (overlap resolves to r0).
- Disable r0; request 0x1000_0004 -> sel=4'b0010. Request 0x5000_0000 -> sel=0, code 1, err_count=1.
- r1 perm=4'b1101; request 0x1000_0000 with mid 1 -> code 2. Same with mid 2 -> sel=4'b0010.
- r1 ctrl=3'b111; prot=3'b000 -> code 3. prot=3'b001 -> ok. prot=3'b011 -> code 3.
- Backpressure: dec_ready=0 for 5 cycles with req_valid high -> req_ready=0, dec_* stable, exactly one result per handshake, no loss or duplication.
- Pulse cfg_lock, then write r0 base=0x8000_0000 -> table unchanged. Apply areset -> cfg_locked=0, all requests return code 1.
